fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO, the next-generation buffer for the push/pull FIFO path used by the UVM labs. It adds configurable data width and depth, a first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full and almost-empty flags, and one-cycle overflow and underflow error pulses. It sits between a producer driving push/d_in and a consumer driving pull/d_out, in one clock domain.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 16, number of storage entries (≥2; need not be a power of two)
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- push  in  1  write request; d_in is captured when the push is accepted
- pull  in  1  read/pop request
- d_in  in  WIDTH  write data
- d_out  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  one-cycle pulse: a push was rejected
- underflow  out  1  one-cycle pulse: a pull was rejected

## Operation
- Storage is a DEPTH×WIDTH array with rd_ptr and wr_ptr. Each pointer increments on an accepted operation and wraps from DEPTH-1 to 0. The array is not reset.
- A push is accepted when (!full) or (full && pull). An accepted push writes d_in to mem[wr_ptr].
- A pull is accepted when !empty. A pull on empty is rejected, including when push is also high.
- Count update per edge:
  - +1 on accepted push only
  - −1 on accepted pull only
  - unchanged when both or neither are accepted
- Full with push and pull both high: both are accepted, count stays at DEPTH, no overflow.
- Empty with push and pull both high: the push is accepted and the pull is rejected. count becomes 1 and underflow pulses.
- Rejected push (full, no pull): data is dropped, no state changes, overflow=1 for the following cycle.
- Rejected pull (empty): no state changes, underflow=1 for the following cycle.
- FWFT=0: on an accepted pull, d_out is loaded with mem[rd_ptr] at that edge. d_out otherwise holds its last value.
- FWFT=1: d_out = mem[rd_ptr] continuously when !empty, and 0 when empty. An accepted pull advances to the next word.
- Flags are decoded from the registered count and change only at clock edges. There is no combinational path from push/pull to any flag.
- Illegal parameters (DEPTH<2, or thresholds out of range) stop elaboration with $error.

## Timing
- Reset (rst=0) takes effect immediately, independent of clk. It forces:
  - count=0, rd_ptr=0, wr_ptr=0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - overflow=0, underflow=0, d_out=0
- Release of rst is synchronised by the integrator. The first operation is honoured on the first rising edge with rst=1.
- Reset mid-operation discards all contents. Post-reset reads return no stale data: d_out=0 and empty=1.
- Write-to-flag latency: push at edge N updates count, empty and almost_* at edge N.
- Write-to-read latency:
  - FWFT=1: the word appears on d_out in the same cycle that empty drops.
  - FWFT=0: a pull can be issued in the cycle after the push edge, and d_out is valid one cycle after the pull edge.
- Read latency: FWFT=0 is 1 cycle (pull at edge N gives data after edge N). FWFT=1 is 0 cycles (data is already present, pull only pops).
- Error pulses are registered, last exactly one cycle per rejected request, and repeat on consecutive rejected cycles.
- Throughput: one push and one pull per cycle, sustained, in every fill state.

## Test plan
- Reset/flags: DEPTH=16, FWFT=0. Hold rst=0 for 3 cycles -> count=0, empty=1, almost_empty=1, full=0, d_out=0. Push 0x1..0xE -> almost_full rises when count=14. Push 0xF, 0x10 -> full=1 at count=16.
- Overflow and ordering: from full, push 0xDEAD without pull -> overflow=1 for 1 cycle, count stays 16. Then 16 pulls return 0x1..0x10 in order, 0xDEAD never appears, empty=1 after the last pull.
- Simultaneous push and pull:
  - At full: push 0xAA plus pull -> count=16, no overflow, 0xAA read 16 pulls later.
  - At empty: push 0xBB plus pull -> count=1, underflow=1, and the next pull returns 0xBB.
- FWFT=1, DEPTH=5: push 0x11 -> d_out=0x11 in the same cycle empty=0. Pull -> d_out=0 and empty=1. Push 10 words with one pull every cycle from cycle 2 -> pointer wrap at 4→0 preserves order.
- Reset mid-operation: with count=7, drop rst asynchronously between edges -> all outputs reach reset values before the next edge. Push 0x55 then pull -> d_out=0x55 (no stale data).
- Thresholds: AF_THRESH=DEPTH, AE_THRESH=0 -> almost_full is equivalent to full and almost_empty is equivalent to empty across a random push/pull sequence of 1000 cycles.

Source files
------------

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised synchronous FIFO with optional first-word-fall-through read
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active low
//   push, d_in          write request and data
//   pull, d_out         read/pop request and data
//   full, empty         count == DEPTH, count == 0
//   almost_full         count >= AF_THRESH
//   almost_empty        count <= AE_THRESH
//   count               current occupancy
//   overflow            one-cycle pulse after a rejected push
//   underflow           one-cycle pulse after a rejected pull
module fifo_param #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter bit FWFT      = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pull,
   input  logic [WIDTH-1:0]             d_in,
   output logic [WIDTH-1:0]             d_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (WIDTH < 1) begin : g_bad_width
      $error("fifo_param: WIDTH must be at least 1");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_param: DEPTH must be at least 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_param: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_param: AE_THRESH must be in 0..DEPTH-1");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             push_ok;
   logic             pull_ok;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full FIFO still takes a push when the same cycle pops, since the pop frees the slot.
   assign pull_ok = pull && !empty;
   assign push_ok = push && (!full || pull);

   // Flags decode only the registered count, so they never see push/pull combinationally.
   assign empty        = (count == '0);
   assign full         = (count == CW'(DEPTH));
   assign almost_full  = (count >= CW'(AF_THRESH));
   assign almost_empty = (count <= CW'(AE_THRESH));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (pull_ok) rd_ptr <= next_ptr(rd_ptr);
         case ({push_ok, pull_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         overflow  <= push && !push_ok;
         underflow <= pull && !pull_ok;
      end
   end

   // Storage carries no reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= d_in;
   end

   if (FWFT) begin : g_fwft
      assign d_out = empty ? '0 : mem[rd_ptr];
   end else begin : g_std
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)         d_out <= '0;
         else if (pull_ok) d_out <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - randomized and directed bench for fifo_param against a queue model
module tb_fifo_param;

   localparam int N = 3;
   localparam int DEP [N] = '{16, 5, 8};
   localparam int AFT [N] = '{14, 3, 8};
   localparam int AET [N] = '{2, 2, 0};
   localparam int FW  [N] = '{0, 1, 0};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        push [N];
   logic        pull [N];
   logic [31:0] din  [N];
   logic [31:0] dout [N];
   logic        full [N];
   logic        empty [N];
   logic        af [N];
   logic        ae [N];
   logic        ovf [N];
   logic        unf [N];
   logic [7:0]  cnt [N];
   logic [4:0]  cnt0;
   logic [2:0]  cnt1;
   logic [3:0]  cnt2;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_param #(.WIDTH(32), .DEPTH(16), .FWFT(1'b0)) u0 (
      .clk(clk), .rst(rst), .push(push[0]), .pull(pull[0]), .d_in(din[0]), .d_out(dout[0]),
      .full(full[0]), .empty(empty[0]), .almost_full(af[0]), .almost_empty(ae[0]),
      .count(cnt0), .overflow(ovf[0]), .underflow(unf[0]));

   fifo_param #(.WIDTH(32), .DEPTH(5), .FWFT(1'b1)) u1 (
      .clk(clk), .rst(rst), .push(push[1]), .pull(pull[1]), .d_in(din[1]), .d_out(dout[1]),
      .full(full[1]), .empty(empty[1]), .almost_full(af[1]), .almost_empty(ae[1]),
      .count(cnt1), .overflow(ovf[1]), .underflow(unf[1]));

   fifo_param #(.WIDTH(32), .DEPTH(8), .AF_THRESH(8), .AE_THRESH(0), .FWFT(1'b0)) u2 (
      .clk(clk), .rst(rst), .push(push[2]), .pull(pull[2]), .d_in(din[2]), .d_out(dout[2]),
      .full(full[2]), .empty(empty[2]), .almost_full(af[2]), .almost_empty(ae[2]),
      .count(cnt2), .overflow(ovf[2]), .underflow(unf[2]));

   assign cnt[0] = 8'(cnt0);
   assign cnt[1] = 8'(cnt1);
   assign cnt[2] = 8'(cnt2);

   task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
      end
   endtask

   // Reference model: one queue per instance holding the stored words in order.
   logic [31:0] mq [N][$];
   logic [31:0] mdo  [N] = '{default: '0};
   logic        movf [N] = '{default: 1'b0};
   logic        munf [N] = '{default: 1'b0};

   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < N; i++) begin
         if (!rst) begin
            mq[i].delete();
            mdo[i]  = '0;
            movf[i] = 1'b0;
            munf[i] = 1'b0;
         end else begin
            int  sz;
            bit  pok;
            bit  plk;
            sz  = mq[i].size();
            plk = pull[i] && (sz > 0);
            pok = push[i] && ((sz < DEP[i]) || pull[i]);
            movf[i] = push[i] && !pok;
            munf[i] = pull[i] && !plk;
            if (plk) begin
               if (FW[i] == 0) mdo[i] = mq[i][0];
               void'(mq[i].pop_front());
            end
            if (pok) mq[i].push_back(din[i]);
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         int sz;
         logic [31:0] exp_do;
         sz = mq[i].size();
         if (FW[i] == 1) exp_do = (sz > 0) ? mq[i][0] : 32'h0;
         else            exp_do = mdo[i];
         chk("count", i, 64'(cnt[i]), 64'(sz));
         chk("full", i, 64'(full[i]), 64'(sz == DEP[i]));
         chk("empty", i, 64'(empty[i]), 64'(sz == 0));
         chk("almost_full", i, 64'(af[i]), 64'(sz >= AFT[i]));
         chk("almost_empty", i, 64'(ae[i]), 64'(sz <= AET[i]));
         chk("overflow", i, 64'(ovf[i]), 64'(movf[i]));
         chk("underflow", i, 64'(unf[i]), 64'(munf[i]));
         chk("d_out", i, 64'(dout[i]), 64'(exp_do));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
         push[i] = 1'b0;
         pull[i] = 1'b0;
      end
   endtask

   task automatic drive(input int i, input logic ps, input logic pl, input logic [31:0] d);
      push[i] = ps;
      pull[i] = pl;
      din[i]  = d;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         push[i] = 1'b0;
         pull[i] = 1'b0;
         din[i]  = '0;
      end

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #2;
      chk("rst_count", 0, 64'(cnt[0]), 64'd0);
      chk("rst_empty", 0, 64'(empty[0]), 64'd1);
      chk("rst_ae", 0, 64'(ae[0]), 64'd1);
      chk("rst_full", 0, 64'(full[0]), 64'd0);
      chk("rst_dout", 0, 64'(dout[0]), 64'd0);
      rst = 1'b1;

      // Fill to full, watching almost_full rise at 14
      for (int k = 1; k <= 16; k++) begin
         drive(0, 1'b1, 1'b0, 32'(k));
         tick();
         if (k == 13) chk("af_at13", 0, 64'(af[0]), 64'd0);
         if (k == 14) chk("af_at14", 0, 64'(af[0]), 64'd1);
      end
      chk("full_at16", 0, 64'(full[0]), 64'd1);
      chk("count_16", 0, 64'(cnt[0]), 64'd16);

      // Rejected push
      drive(0, 1'b1, 1'b0, 32'hDEAD);
      tick();
      chk("ovf_pulse", 0, 64'(ovf[0]), 64'd1);
      chk("ovf_count", 0, 64'(cnt[0]), 64'd16);
      tick();
      chk("ovf_clear", 0, 64'(ovf[0]), 64'd0);

      // Drain in order
      for (int k = 1; k <= 16; k++) begin
         drive(0, 1'b0, 1'b1, 32'h0);
         tick();
         chk("drain_data", 0, 64'(dout[0]), 64'(k));
      end
      chk("drain_empty", 0, 64'(empty[0]), 64'd1);

      // Simultaneous push+pull at full
      for (int k = 1; k <= 16; k++) begin
         drive(0, 1'b1, 1'b0, 32'h100 + 32'(k));
         tick();
      end
      drive(0, 1'b1, 1'b1, 32'hAA);
      tick();
      chk("pp_full_count", 0, 64'(cnt[0]), 64'd16);
      chk("pp_full_ovf", 0, 64'(ovf[0]), 64'd0);
      chk("pp_full_dout", 0, 64'(dout[0]), 64'h101);
      for (int k = 2; k <= 16; k++) begin
         drive(0, 1'b0, 1'b1, 32'h0);
         tick();
         chk("pp_drain", 0, 64'(dout[0]), 64'h100 + 64'(k));
      end
      drive(0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("pp_aa", 0, 64'(dout[0]), 64'hAA);
      chk("pp_aa_empty", 0, 64'(empty[0]), 64'd1);

      // Simultaneous push+pull at empty
      drive(0, 1'b1, 1'b1, 32'hBB);
      tick();
      chk("pe_count", 0, 64'(cnt[0]), 64'd1);
      chk("pe_unf", 0, 64'(unf[0]), 64'd1);
      drive(0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("pe_dout", 0, 64'(dout[0]), 64'hBB);
      chk("pe_empty", 0, 64'(empty[0]), 64'd1);

      // FWFT, DEPTH=5
      drive(1, 1'b1, 1'b0, 32'h11);
      tick();
      chk("fwft_empty", 1, 64'(empty[1]), 64'd0);
      chk("fwft_dout", 1, 64'(dout[1]), 64'h11);
      drive(1, 1'b0, 1'b1, 32'h0);
      tick();
      chk("fwft_pop_dout", 1, 64'(dout[1]), 64'd0);
      chk("fwft_pop_empty", 1, 64'(empty[1]), 64'd1);
      for (int c = 0; c <= 10; c++) begin
         if (c >= 1) chk("fwft_wrap", 1, 64'(dout[1]), 64'h200 + 64'(c - 1));
         drive(1, c < 10, c >= 1, 32'h200 + 32'(c));
         tick();
      end
      chk("fwft_wrap_empty", 1, 64'(empty[1]), 64'd1);

      // Asynchronous reset mid-operation
      for (int k = 0; k < 7; k++) begin
         drive(0, 1'b1, 1'b0, 32'h300 + 32'(k));
         tick();
      end
      chk("pre_rst_count", 0, 64'(cnt[0]), 64'd7);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_count", 0, 64'(cnt[0]), 64'd0);
      chk("arst_empty", 0, 64'(empty[0]), 64'd1);
      chk("arst_dout", 0, 64'(dout[0]), 64'd0);
      chk("arst_ae", 0, 64'(ae[0]), 64'd1);
      #1 rst = 1'b1;
      drive(0, 1'b1, 1'b0, 32'h55);
      tick();
      drive(0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("post_rst_dout", 0, 64'(dout[0]), 64'h55);
      chk("post_rst_empty", 0, 64'(empty[0]), 64'd1);

      // Random traffic on all instances with alternating fill/drain bias
      for (int c = 0; c < 1000; c++) begin
         for (int i = 0; i < N; i++) begin
            int bias;
            bias = ((c / 100) % 2 == 0) ? 3 : 1;
            drive(i, $urandom_range(3, 0) < bias, $urandom_range(3, 0) >= bias, $urandom);
         end
         tick();
      end
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
